// File: rtl/dmem.sv
// Word-organised data RAM with byte-lane writes, registered reads and a post-reset clear sweep.
// Optional macro DMEM_BYPASS_EN selects write-first same-word collision behaviour.
module dmem #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] ram_r_addr,
    input  logic [29:0] ram_w_addr,
    input  logic [31:0] ram_w_data,
    input  logic [3:0]  ram_byte_en,
    input  logic        ram_w_en,
    output logic [31:0] ram_r_data,
    output logic        busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]       rd_data_q, rd_word;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] r_idx, w_idx;
    logic              wr_fire;
    logic [31:0]       old_word, merged_word;

    // Upper address bits alias silently onto the implemented range.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram_r_addr[29:ADDR_W], ram_w_addr[29:ADDR_W]};

    assign r_idx   = ram_r_addr[ADDR_W-1:0];
    assign w_idx   = ram_w_addr[ADDR_W-1:0];
    assign wr_fire = (state_q == ST_READY) && ram_w_en;

    always_comb begin
        old_word    = mem[r_idx];
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wr_fire && (w_idx == r_idx) && ram_byte_en[i]) begin
                merged_word[8*i +: 8] = ram_w_data[8*i +: 8];
            end
        end
`ifdef DMEM_BYPASS_EN
        rd_word = merged_word;
`else
        rd_word = old_word;
`endif
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
            if (clr_idx_q == {ADDR_W{1'b1}}) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rd_data_q <= (state_q == ST_READY) ? rd_word : 32'h0;
        end
    end

    // Storage has no reset; the clear sweep initialises it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem[clr_idx_q] <= 32'h0;
            end else if (ram_w_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (ram_byte_en[i]) begin
                        mem[w_idx][8*i +: 8] <= ram_w_data[8*i +: 8];
                    end
                end
            end
        end
    end

    assign ram_r_data = rd_data_q;
    assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem with ADDR_W=4.
module tb_dmem;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] ram_r_addr;
    logic [29:0] ram_w_addr;
    logic [31:0] ram_w_data;
    logic [3:0]  ram_byte_en;
    logic        ram_w_en;
    logic [31:0] ram_r_data;
    logic        busy;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    dmem #(.ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ram_r_addr (ram_r_addr),
        .ram_w_addr (ram_w_addr),
        .ram_w_data (ram_w_data),
        .ram_byte_en(ram_byte_en),
        .ram_w_en   (ram_w_en),
        .ram_r_data (ram_r_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one edge; return at the following falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count busy-high samples (one per cycle) with a bounded wait; r_data must stay 0.
    task automatic count_busy(input string tag, output int n);
        logic [31:0] rd_or;
        n     = 0;
        rd_or = 32'h0;
        while (busy === 1'b1 && n < 100) begin
            rd_or |= ram_r_data;
            n++;
            step();
        end
        chk({tag, "_len"}, 32'(n), 32'd16);
        chk({tag, "_rdata_zero"}, rd_or, 32'h0);
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] en);
        ram_w_addr  = a;
        ram_w_data  = d;
        ram_byte_en = en;
        ram_w_en    = 1'b1;
        step();
        ram_w_en    = 1'b0;
        ram_byte_en = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [29:0] a, input logic [31:0] exp);
        ram_r_addr = a;
        step();
        chk(tag, ram_r_data, exp);
    endtask

    initial begin
        int n;
        logic [31:0] exp_coll;

        rst         = 1'b1;
        ram_r_addr  = 30'h0;
        ram_w_addr  = 30'h0;
        ram_w_data  = 32'h0;
        ram_byte_en = 4'h0;
        ram_w_en    = 1'b0;
        @(negedge clk);
        step();
        rst = 1'b0;
        chk("reset_busy", {31'h0, busy}, 32'h1);
        chk("reset_rdata", ram_r_data, 32'h0);

        // Write attempted during the sweep must be dropped.
        ram_w_addr  = 30'h2;
        ram_w_data  = 32'hDEADBEEF;
        ram_byte_en = 4'hF;
        ram_w_en    = 1'b1;
        ram_r_addr  = 30'h7;
        count_busy("clear", n);
        ram_w_en    = 1'b0;
        ram_byte_en = 4'h0;
        chk("clear_busy_low", {31'h0, busy}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            rd_chk($sformatf("clear_word%0d", i), 30'(i), 32'h0);
        end

        wr(30'h3, 32'hAABBCCDD, 4'b1111);
        rd_chk("lane_full", 30'h3, 32'hAABBCCDD);
        wr(30'h3, 32'h00001122, 4'b0011);
        wr(30'h3, 32'h77000000, 4'b1000);
        rd_chk("lane_merge", 30'h3, 32'h77BB1122);
        wr(30'h3, 32'h55555555, 4'b0000);
        rd_chk("lane_no_en", 30'h3, 32'h77BB1122);

        wr(30'h5, 32'h11111111, 4'b1111);
        ram_r_addr = 30'h5;
`ifdef DMEM_BYPASS_EN
        exp_coll = 32'h11111122;
`else
        exp_coll = 32'h11111111;
`endif
        wr(30'h5, 32'h22222222, 4'b0001);
        chk("collision_same_edge", ram_r_data, exp_coll);
        rd_chk("collision_after", 30'h5, 32'h11111122);

        // Alias write to word 0 while reading word 3 on the same edge.
        ram_r_addr = 30'h3;
        wr(30'h10, 32'hCAFEF00D, 4'b1111);
        chk("independent_rd", ram_r_data, 32'h77BB1122);
        rd_chk("alias_rd0", 30'h0, 32'hCAFEF00D);
        rd_chk("alias_rd_hi", 30'h3FFF_FFF0, 32'hCAFEF00D);

        // Reset during READY with a write presented on that edge.
        rst = 1'b1;
        wr(30'h6, 32'h12345678, 4'b1111);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midclear_rdata", ram_r_data, 32'h0);
        count_busy("midclear", n);
        for (int i = 0; i < 16; i++) begin
            rd_chk($sformatf("midclear_word%0d", i), 30'(i), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem.md
# dmem

Synchronous word-organised data RAM that is the responder for the memory stage's RAM request port. Accepts one byte-enabled write and one word read per cycle and returns registered read data to the writeback path. After reset, a hardware clear sequence zeroes every word; `busy` stays high until it finishes.

## Interface
Parameters:
- `ADDR_W`, default 10: number of implemented word-address bits; depth is 2^ADDR_W 32-bit words.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ram_r_addr`  in  30  read word address (byte address [31:2]); only [ADDR_W-1:0] used.
- `ram_w_addr`  in  30  write word address; only [ADDR_W-1:0] used.
- `ram_w_data`  in  32  write data, lane-aligned; lane i = bits [8i+7:8i].
- `ram_byte_en`  in  4  per-lane write enable; bit i enables lane i.
- `ram_w_en`  in  1  write strobe.
- `ram_r_data`  out  32  registered read data.
- `busy`  out  1  high while the clear sequence runs.

## Operation
- Address aliasing: bits [29:ADDR_W] of both addresses are ignored, with no error or flag.
- Write:
  - Takes effect when `ram_w_en`=1 and state is READY.
  - Each lane i with `ram_byte_en[i]`=1 is written from `ram_w_data` lane i.
  - Other lanes keep their contents.
  - `ram_w_en`=1 with `ram_byte_en`=0 is a no-op.
- Read:
  - Unconditional every cycle; there is no read enable.
  - `ram_r_addr` is sampled at each edge.
- State machine, two states:
  - CLEAR: a counter `clr_idx` (ADDR_W bits) writes 32'h0 to word `clr_idx` each cycle, then increments. The external write port is ignored. `ram_r_data` is forced to 0.
  - On the edge that clears word 2^ADDR_W-1: state goes to READY and `clr_idx` wraps to 0.
  - READY: normal read/write service. No exit except `rst`.
- Reset (`rst`=1 at an edge):
  - State goes to CLEAR, `clr_idx` goes to 0, `busy` goes to 1, `ram_r_data` goes to 0.
  - Reset during CLEAR restarts the sweep from word 0.
  - Reset during READY discards any write presented on that edge.
- Reset values: `ram_r_data`=0, `busy`=1.

## Timing
- Read latency is 1 cycle: `ram_r_data` after edge N reflects `ram_r_addr` sampled at edge N.
- Write is visible to a read of the same word sampled at edge N+1 or later.
- Clear duration is 2^ADDR_W cycles after reset deassertion.
- `busy` falls on the same edge the last word is cleared. The first serviced write/read is on the following edge.
- Read and write to different words on the same edge are independent.
- Same-word read and write on the same edge are governed by `DMEM_BYPASS_EN` (see Configuration).

## Configuration
- `DMEM_BYPASS_EN` defined (write-first):
  - On a same-edge read and write of the same word, `ram_r_data` returns the merged word: enabled lanes from `ram_w_data`, other lanes from the old contents.
- `DMEM_BYPASS_EN` undefined (read-first):
  - `ram_r_data` returns the pre-write contents.
  - The write still completes on that edge.
- In both modes, behaviour during CLEAR is unchanged.

## Test plan
- Reset clear, with ADDR_W=4:
  - Stimulus: assert `rst` 1 cycle, then sample.
  - Required: `busy`=1 for exactly 16 cycles then 0. Reading words 0..15 afterwards returns 0. `ram_r_data`=0 throughout CLEAR.
- Byte lanes:
  - Stimulus: write 32'hAABBCCDD with en=4'b1111 to word 3, then 32'h00001122 with en=4'b0011 to word 3, then 32'h77000000 with en=4'b1000 to word 3.
  - Required: read of word 3 returns 32'h77BB1122 one cycle later.
- Same-word collision:
  - Stimulus: word 5 holds 32'h11111111. On one edge, read word 5 and write 32'h2222_2222 with en=4'b0001.
  - Required: `ram_r_data`=32'h11111122 with `DMEM_BYPASS_EN`, 32'h11111111 without. The next read returns 32'h11111122 in both modes.
- Write ignored while busy:
  - Stimulus: during CLEAR, present a write of 32'hDEADBEEF, en=4'b1111, to word 2.
  - Required: after `busy` falls, word 2 reads 0.
- Reset mid-clear:
  - Stimulus: assert `rst` when `clr_idx`=9 (ADDR_W=4).
  - Required: `busy` stays 1 for 16 further cycles, and all words read 0 afterwards.
- Aliasing:
  - Stimulus: with ADDR_W=4, write 32'hCAFEF00D to address 30'h10 (en=4'b1111).
  - Required: a read of address 30'h0 returns 32'hCAFEF00D.
